vram_arbiter: RTL and testbench

Single-port video-RAM arbiter between the MIPS core's memory-mapped framebuffer accesses and the VGA scan-out engine. It keeps a small prefetch FIFO of pixels ahead of the VGA timing generator and gives the CPU the RAM port whenever the FIFO is safely above its low-water mark. It sits between the core's data-bus decoder, the VGA sync/colour logic and the block RAM that holds the framebuffer.

---
 rtl/vram_arb_pkg.sv | 22 ++
 rtl/pix_fifo.sv | 72 +++++++
 rtl/vram_arbiter.sv | 147 ++++++++++++++
 tb/tb_vram_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_arb_pkg.sv
// vram_arb_pkg: shared types and default sizes for the video-RAM arbiter.
//   gnt_t     - per-cycle owner of the single RAM port
//   rgb332_t  - framebuffer pixel layout (R3 G3 B2)
package vram_arb_pkg;

    localparam int unsigned VRAM_ADDR_W   = 15;
    localparam int unsigned VRAM_DATA_W   = 8;
    localparam int unsigned VRAM_FB_WORDS = 19200;  // 160x120

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_VGA  = 2'd1,
        GNT_CPU  = 2'd2
    } gnt_t;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } rgb332_t;

endpackage

// File: rtl/pix_fifo.sv
// pix_fifo: synchronous first-word-fall-through FIFO for prefetched pixels.
//   clk, rst    - clock, synchronous active-high reset
//   flush       - discard all entries (head keeps showing the last popped word)
//   push        - write push_data (ignored when full unless popping too)
//   pop         - remove head (ignored when empty, flagged on empty_pop)
//   head        - current head; last popped word while empty
//   count       - number of stored entries
//   empty_pop   - pop requested while empty (combinational)
module pix_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CW     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [CW-1:0]     count,
    output logic              empty_pop
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [DATA_W-1:0] last_q;
    logic              do_push;
    logic              do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop    = pop && (count != '0);
    assign do_push   = push && ((count != CW'(DEPTH)) || do_pop);
    assign empty_pop = pop && (count == '0);
    // last_q keeps the output stable once the FIFO runs dry
    assign head      = (count != '0) ? mem[rd_ptr] : last_q;

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            last_q <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
                last_q <= mem[rd_ptr];
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port framebuffer RAM arbiter between CPU accesses and
// the VGA prefetch FIFO.
//   clk, rst                      - clock, synchronous active-high reset
//   fb_base                       - frame start address, taken on vga_frame_start
//   cpu_req/we/addr/wdata         - CPU access, req held until cpu_ack
//   cpu_rdata, cpu_ack            - read data (held between acks), completion pulse
//   vga_frame_start, vga_pix_rd   - restart/flush, pop FIFO head
//   vga_pix, vga_underrun         - FWFT head, sticky empty-pop flag
//   ram_en/we/addr/wdata, ram_rdata - registered RAM port, 1-cycle read latency
// Optional: VRAM_ARB_UNDERRUN_CNT_EN adds underrun_cnt (saturating empty-pop count).
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = VRAM_ADDR_W,
    parameter int unsigned DATA_W     = VRAM_DATA_W,
    parameter int unsigned FB_WORDS   = VRAM_FB_WORDS,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned LOW_WATER  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] fb_base,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              vga_frame_start,
    input  logic              vga_pix_rd,
    output logic [DATA_W-1:0] vga_pix,
    output logic              vga_underrun,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
`ifdef VRAM_ARB_UNDERRUN_CNT_EN
    ,
    output logic [15:0]       underrun_cnt
`endif
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned LW = CW + 1;

    gnt_t              gnt;
    logic              s1_vga;      // VGA read on the RAM port this cycle
    logic              s2_vga;      // VGA read data on ram_rdata this cycle
    logic              s1_cpu;      // CPU op on the RAM port; cpu_ack is stage 2
    logic [CW-1:0]     fifo_count;
    logic [LW-1:0]     level;
    logic [ADDR_W-1:0] fetch_addr;
    logic [ADDR_W-1:0] frame_base;
    logic [ADDR_W-1:0] last_addr;
    logic [DATA_W-1:0] rdata_hold;
    logic              fifo_pop;
    logic              fifo_push;
    logic              empty_pop;

    // Reads in flight count towards the level so the FIFO can never overflow.
    assign level     = LW'(fifo_count) + LW'(s1_vga) + LW'(s2_vga);
    assign last_addr = frame_base + ADDR_W'(FB_WORDS - 1);
    assign fifo_pop  = vga_pix_rd && !vga_frame_start;
    assign fifo_push = s2_vga && !vga_frame_start;
    assign cpu_rdata = cpu_ack ? ram_rdata : rdata_hold;

    always_comb begin
        gnt = GNT_NONE;
        if (level < LW'(LOW_WATER)) begin
            gnt = GNT_VGA;
        end else if (cpu_req && !s1_cpu && !cpu_ack) begin
            gnt = GNT_CPU;
        end else if (level < LW'(FIFO_DEPTH)) begin
            gnt = GNT_VGA;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ram_en       <= 1'b0;
            ram_we       <= 1'b0;
            ram_addr     <= '0;
            ram_wdata    <= '0;
            s1_vga       <= 1'b0;
            s2_vga       <= 1'b0;
            s1_cpu       <= 1'b0;
            cpu_ack      <= 1'b0;
            rdata_hold   <= '0;
            fetch_addr   <= '0;
            frame_base   <= '0;
            vga_underrun <= 1'b0;
        end else begin
            ram_en   <= (gnt != GNT_NONE);
            ram_we   <= (gnt == GNT_CPU) && cpu_we;
            ram_addr <= (gnt == GNT_CPU) ? cpu_addr : fetch_addr;
            if ((gnt == GNT_CPU) && cpu_we) begin
                ram_wdata <= cpu_wdata;
            end
            s1_cpu  <= (gnt == GNT_CPU);
            cpu_ack <= s1_cpu;
            if (cpu_ack) begin
                rdata_hold <= ram_rdata;
            end
            // Frame start marks every VGA read in the pipe (including this
            // cycle's grant) stale by dropping its tag; the data is ignored.
            s1_vga <= (gnt == GNT_VGA) && !vga_frame_start;
            s2_vga <= s1_vga && !vga_frame_start;
            if (vga_frame_start) begin
                frame_base <= fb_base;
                fetch_addr <= fb_base;
            end else if (gnt == GNT_VGA) begin
                fetch_addr <= (fetch_addr == last_addr) ? frame_base : fetch_addr + 1'b1;
            end
            if (empty_pop) begin
                vga_underrun <= 1'b1;
            end
        end
    end

`ifdef VRAM_ARB_UNDERRUN_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            underrun_cnt <= '0;
        end else if (empty_pop && (underrun_cnt != '1)) begin
            underrun_cnt <= underrun_cnt + 1'b1;
        end
    end
`endif

    pix_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH),
        .CW     (CW)
    ) u_pix_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (vga_frame_start),
        .push      (fifo_push),
        .push_data (ram_rdata),
        .pop       (fifo_pop),
        .head      (vga_pix),
        .count     (fifo_count),
        .empty_pop (empty_pop)
    );

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: scoreboard bench for vram_arbiter with a behavioural
// one-cycle-latency RAM. Build with VRAM_ARB_UNDERRUN_CNT_EN to cover underrun_cnt.
module tb_vram_arbiter;

    localparam int unsigned AW  = 15;
    localparam int unsigned DW  = 8;
    localparam int unsigned FBW = 19200;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] fb_base = '0;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack;
    logic          vga_frame_start = 1'b0;
    logic          vga_pix_rd = 1'b0;
    logic [DW-1:0] vga_pix;
    logic          vga_underrun;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;
`ifdef VRAM_ARB_UNDERRUN_CNT_EN
    logic [15:0]   underrun_cnt;
`endif

    vram_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .FB_WORDS   (FBW),
        .FIFO_DEPTH (4),
        .LOW_WATER  (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .fb_base         (fb_base),
        .cpu_req         (cpu_req),
        .cpu_we          (cpu_we),
        .cpu_addr        (cpu_addr),
        .cpu_wdata       (cpu_wdata),
        .cpu_rdata       (cpu_rdata),
        .cpu_ack         (cpu_ack),
        .vga_frame_start (vga_frame_start),
        .vga_pix_rd      (vga_pix_rd),
        .vga_pix         (vga_pix),
        .vga_underrun    (vga_underrun),
        .ram_en          (ram_en),
        .ram_we          (ram_we),
        .ram_addr        (ram_addr),
        .ram_wdata       (ram_wdata),
        .ram_rdata       (ram_rdata)
`ifdef VRAM_ARB_UNDERRUN_CNT_EN
        ,
        .underrun_cnt    (underrun_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Framebuffer RAM and the bench's own copy of what it should contain
    logic [DW-1:0] ram_mem [32768];
    logic [DW-1:0] exp_mem [32768];

    function automatic logic [DW-1:0] init_val(input int unsigned a);
        return DW'((a * 37) ^ (a >> 7) ^ 32'h5A);
    endfunction

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) ram_mem[ram_addr] <= ram_wdata;
            ram_rdata <= ram_mem[ram_addr];
        end
    end

    int unsigned checks = 0;
    int unsigned errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        bit            rd;
        logic [DW-1:0] d;
    } cpu_exp_t;

    logic [DW-1:0] pix_q [$];
    logic [AW-1:0] addr_q [$];
    cpu_exp_t      cpu_q [$];

    logic [AW-1:0] vga_base = '0;
    logic [AW-1:0] vga_next = '0;
    logic [AW-1:0] wrap_last = '0;
    logic [AW-1:0] prev_rd = '0;
    bit            prev_valid = 1'b0;
    bit            addr_mon = 1'b0;
    bit            wrap_mon = 1'b0;
    bit            stress_done = 1'b0;
    int unsigned   extra_reads = 0;
    int unsigned   spurious_acks = 0;
    int unsigned   wrap_seen = 0;

    function automatic logic [AW-1:0] model_next(input logic [AW-1:0] a);
        logic [AW-1:0] last;
        last = vga_base + AW'(FBW - 1);
        return (a == last) ? vga_base : a + 1'b1;
    endfunction

    // Output side of the scoreboards
    always @(negedge clk) begin
        cpu_exp_t e;
        if (vga_pix_rd && pix_q.size() != 0) begin
            check("vga_pix", 32'(vga_pix), 32'(pix_q.pop_front()));
        end
        if (cpu_ack) begin
            if (cpu_q.size() == 0) begin
                spurious_acks++;
            end else begin
                e = cpu_q.pop_front();
                if (e.rd) check("cpu_rdata", 32'(cpu_rdata), 32'(e.d));
            end
        end
        if (addr_mon && ram_en && !ram_we) begin
            if (addr_q.size() != 0) check("fetch_addr", 32'(ram_addr), 32'(addr_q.pop_front()));
            else extra_reads++;
        end
        if (wrap_mon && ram_en && !ram_we) begin
            if (prev_valid && prev_rd == wrap_last) begin
                check("wrap_addr", 32'(ram_addr), 32'(vga_base));
                wrap_seen++;
            end
            prev_rd    = ram_addr;
            prev_valid = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cpu_req = 1'b0;
        vga_pix_rd = 1'b0;
        vga_frame_start = 1'b0;
        step();
        step();
        check("rst_underrun", 32'(vga_underrun), 0);
        check("rst_cpu_ack", 32'(cpu_ack), 0);
`ifdef VRAM_ARB_UNDERRUN_CNT_EN
        check("rst_underrun_cnt", 32'(underrun_cnt), 0);
`endif
        rst = 1'b0;
        vga_base = '0;
        vga_next = '0;
    endtask

    task automatic frame_start(input logic [AW-1:0] base, input bit with_pop);
        step();
        fb_base = base;
        vga_frame_start = 1'b1;
        vga_pix_rd = with_pop;
        step();
        vga_frame_start = 1'b0;
        vga_pix_rd = 1'b0;
        vga_base = base;
        vga_next = base;
    endtask

    task automatic pop_stream(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            step();
            vga_pix_rd = 1'b1;
            pix_q.push_back(exp_mem[vga_next]);
            vga_next = model_next(vga_next);
        end
        step();
        vga_pix_rd = 1'b0;
    endtask

    // Issues one CPU op in the next cycle and waits for its ack; req is left
    // high so consecutive calls model a back-to-back requester.
    task automatic cpu_op(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input bit strict);
        int unsigned n;
        step();
        cpu_req = 1'b1;
        cpu_we = we;
        cpu_addr = a;
        cpu_wdata = d;
        if (we) begin
            exp_mem[a] = d;
            cpu_q.push_back('{rd: 1'b0, d: '0});
        end else begin
            cpu_q.push_back('{rd: 1'b1, d: exp_mem[a]});
        end
        n = 0;
        @(negedge clk);
        while (!cpu_ack && n < 50) begin
            @(negedge clk);
            n++;
            if (strict && n == 1) begin
                check("ram_en_n1", 32'(ram_en), 1);
                check("ram_we_n1", 32'(ram_we), 32'(we));
                check("ram_addr_n1", 32'(ram_addr), 32'(a));
                if (we) check("ram_wdata_n1", 32'(ram_wdata), 32'(d));
            end
        end
        if (strict) check("cpu_latency", n, 2);
        else check("cpu_wait_bound", 32'(n <= 8), 1);
    endtask

    initial begin
        for (int unsigned i = 0; i < 32768; i++) begin
            ram_mem[i] = init_val(i);
            exp_mem[i] = init_val(i);
        end

        // Reset state
        rst = 1'b1;
        repeat (3) step();
        check("reset_ram_en", 32'(ram_en), 0);
        check("reset_ram_we", 32'(ram_we), 0);
        check("reset_ram_addr", 32'(ram_addr), 0);
        check("reset_ram_wdata", 32'(ram_wdata), 0);
        check("reset_cpu_ack", 32'(cpu_ack), 0);
        check("reset_cpu_rdata", 32'(cpu_rdata), 0);
        check("reset_vga_pix", 32'(vga_pix), 0);
        check("reset_underrun", 32'(vga_underrun), 0);

        // Three pops on the empty FIFO straight out of reset
        rst = 1'b0;
        vga_pix_rd = 1'b1;
        step();
        @(negedge clk);
        check("underrun_set", 32'(vga_underrun), 1);
        check("underrun_pix_hold", 32'(vga_pix), 0);
        step();
        step();
        vga_pix_rd = 1'b0;
        @(negedge clk);
`ifdef VRAM_ARB_UNDERRUN_CNT_EN
        check("underrun_cnt", 32'(underrun_cnt), 3);
`endif
        check("underrun_sticky", 32'(vga_underrun), 1);
        do_reset();

        // Frame start at 0x0100 with no pops: four fetches, then idle
        repeat (8) step();
        for (int unsigned i = 0; i < 4; i++) addr_q.push_back(AW'(32'h0100 + i));
        addr_mon = 1'b1;
        frame_start(15'h0100, 1'b0);
        repeat (10) step();
        addr_mon = 1'b0;
        check("fetch_left", addr_q.size(), 0);
        check("idle_reads", extra_reads, 0);

        // CPU write then read with the FIFO full
        cpu_op(1'b1, 15'h0200, 8'hE3, 1'b1);
        cpu_op(1'b0, 15'h0200, 8'h00, 1'b1);
        step();
        cpu_req = 1'b0;
        repeat (3) step();
        check("cpu_rdata_hold", 32'(cpu_rdata), 'hE3);

        // Pixel stream every other cycle with a back-to-back CPU requester
        stress_done = 1'b0;
        fork
            begin
                for (int unsigned i = 0; i < 16; i++)
                    cpu_op(1'b1, AW'(32'h6000 + i), DW'(i * 13 + 5), 1'b0);
                for (int unsigned i = 0; i < 16; i++)
                    cpu_op(1'b0, AW'(32'h6000 + i), 8'h00, 1'b0);
                step();
                cpu_req = 1'b0;
                stress_done = 1'b1;
            end
            begin
                int unsigned c;
                c = 0;
                while (!stress_done && c < 4000) begin
                    step();
                    vga_pix_rd = 1'b1;
                    pix_q.push_back(exp_mem[vga_next]);
                    vga_next = model_next(vga_next);
                    step();
                    vga_pix_rd = 1'b0;
                    c++;
                end
            end
        join
        check("stress_no_underrun", 32'(vga_underrun), 0);
        check("stress_cpu_drained", cpu_q.size(), 0);

        // Frame start with two reads in flight and a same-cycle pop
        repeat (8) step();
        pop_stream(2);
        frame_start(15'h3000, 1'b1);
        repeat (7) step();
        pop_stream(6);
        check("flush_no_underrun", 32'(vga_underrun), 0);

        // Reset while a CPU read is in flight: no ack may follow
        step();
        cpu_req = 1'b1;
        cpu_we = 1'b0;
        cpu_addr = 15'h0050;
        step();
        rst = 1'b1;
        cpu_req = 1'b0;
        step();
        step();
        rst = 1'b0;
        vga_base = '0;
        vga_next = '0;
        repeat (6) step();
        check("rst_no_ack", spurious_acks, 0);

        // Full-frame fetch from 0x4AFF crossing the wrap point
        repeat (4) step();
        frame_start(15'h4AFF, 1'b0);
        wrap_last = vga_base + AW'(FBW - 1);
        wrap_mon = 1'b1;
        repeat (8) step();
        pop_stream(FBW + 10);
        wrap_mon = 1'b0;
        check("wrap_seen", wrap_seen, 1);
        check("wrap_no_underrun", 32'(vga_underrun), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog");
    end

endmodule
